// File: rtl/clock_set_controller.sv
// Time-set sequencer for the hh:mm:ss counter: 1 Hz tick prescaler plus two-button edit FSM.
// Optional alarm registers/states are enabled with `define CLOCK_ALARM_EN.
module clock_set_controller #(
   parameter int CLK_HZ    = 50000000,
   parameter int BLINK_DIV = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       mode_btn,
   input  logic       inc_btn,
   input  logic [5:0] cur_hours,
   input  logic [5:0] cur_minutes,
   input  logic [5:0] cur_seconds,
   output logic       tick,
   output logic       load,
   output logic [5:0] load_hours,
   output logic [5:0] load_minutes,
   output logic [5:0] load_seconds,
   output logic [1:0] edit_field,
   output logic       blink
`ifdef CLOCK_ALARM_EN
  ,input  logic       alarm_set
  ,output logic       alarm
`endif
);

   localparam int PW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_DIV - 1);
   localparam logic [BW-1:0] BLINK_ONE = BW'(1);

   localparam logic [2:0] RUN   = 3'd0;
   localparam logic [2:0] SET_H = 3'd1;
   localparam logic [2:0] SET_M = 3'd2;
   localparam logic [2:0] SET_S = 3'd3;
   localparam logic [2:0] ALM_H = 3'd4;
   localparam logic [2:0] ALM_M = 3'd5;

   logic [2:0]    state_r, state_nx_s;
   logic [PW-1:0] presc_r;
   logic [BW-1:0] blink_cnt_r;
   logic          tick_r, load_r, blink_r;
   logic [1:0]    edit_field_r;
   logic [5:0]    sh_h_r, sh_m_r, sh_s_r;
   logic [5:0]    sh_h_nx_s, sh_m_nx_s, sh_s_nx_s;
   logic          load_nx_s;
`ifdef CLOCK_ALARM_EN
   logic [5:0]    alm_h_r, alm_m_r, alm_h_nx_s, alm_m_nx_s;
   logic          alarm_r, alarm_nx_s;
`endif

   // Out-of-range values also wrap to 0 so a corrupted field recovers on the next press.
   function automatic logic [5:0] inc_wrap(input logic [5:0] v, input logic [5:0] max);
      if (v >= max) begin
         return 6'd0;
      end else begin
         return v + 6'd1;
      end
   endfunction

   function automatic logic [1:0] field_of(input logic [2:0] st);
      case (st)
         SET_H:   return 2'd1;
         SET_M:   return 2'd2;
         SET_S:   return 2'd3;
         ALM_H:   return 2'd1;
         ALM_M:   return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

   // Next-state, shadow edit and load decision; mode_btn always takes priority over inc_btn.
   always_comb begin
      state_nx_s = state_r;
      sh_h_nx_s  = sh_h_r;
      sh_m_nx_s  = sh_m_r;
      sh_s_nx_s  = sh_s_r;
      load_nx_s  = 1'b0;
`ifdef CLOCK_ALARM_EN
      alm_h_nx_s = alm_h_r;
      alm_m_nx_s = alm_m_r;
      alarm_nx_s = alarm_r;
`endif
      case (state_r)
         RUN: begin
`ifdef CLOCK_ALARM_EN
            if (alarm_r && (mode_btn || inc_btn)) begin
               alarm_nx_s = 1'b0;
            end else if (mode_btn) begin
               state_nx_s = SET_H;
               sh_h_nx_s  = cur_hours;
               sh_m_nx_s  = cur_minutes;
               sh_s_nx_s  = cur_seconds;
            end else if (tick_r && (cur_hours == alm_h_r) && (cur_minutes == alm_m_r)
                         && (cur_seconds == 6'd0)) begin
               alarm_nx_s = 1'b1;
            end else begin
               alarm_nx_s = alarm_r;
            end
`else
            if (mode_btn) begin
               state_nx_s = SET_H;
               sh_h_nx_s  = cur_hours;
               sh_m_nx_s  = cur_minutes;
               sh_s_nx_s  = cur_seconds;
            end else begin
               state_nx_s = RUN;
            end
`endif
         end
         SET_H: begin
            if (mode_btn) begin
               state_nx_s = SET_M;
            end else if (inc_btn) begin
               sh_h_nx_s = inc_wrap(sh_h_r, 6'd23);
            end else begin
               state_nx_s = SET_H;
            end
         end
         SET_M: begin
            if (mode_btn) begin
               state_nx_s = SET_S;
            end else if (inc_btn) begin
               sh_m_nx_s = inc_wrap(sh_m_r, 6'd59);
            end else begin
               state_nx_s = SET_M;
            end
         end
         SET_S: begin
            if (mode_btn) begin
               load_nx_s = 1'b1;
`ifdef CLOCK_ALARM_EN
               state_nx_s = alarm_set ? ALM_H : RUN;
`else
               state_nx_s = RUN;
`endif
            end else if (inc_btn) begin
               sh_s_nx_s = inc_wrap(sh_s_r, 6'd59);
            end else begin
               state_nx_s = SET_S;
            end
         end
`ifdef CLOCK_ALARM_EN
         ALM_H: begin
            if (mode_btn) begin
               state_nx_s = ALM_M;
            end else if (inc_btn) begin
               alm_h_nx_s = inc_wrap(alm_h_r, 6'd23);
            end else begin
               state_nx_s = ALM_H;
            end
         end
         ALM_M: begin
            if (mode_btn) begin
               state_nx_s = RUN;
            end else if (inc_btn) begin
               alm_m_nx_s = inc_wrap(alm_m_r, 6'd59);
            end else begin
               state_nx_s = ALM_M;
            end
         end
`endif
         default: begin
            state_nx_s = RUN;
         end
      endcase
   end

   // State, shadow registers and registered strobes.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= RUN;
         sh_h_r       <= 6'd0;
         sh_m_r       <= 6'd0;
         sh_s_r       <= 6'd0;
         load_r       <= 1'b0;
         edit_field_r <= 2'd0;
      end else begin
         state_r      <= state_nx_s;
         sh_h_r       <= sh_h_nx_s;
         sh_m_r       <= sh_m_nx_s;
         sh_s_r       <= sh_s_nx_s;
         load_r       <= load_nx_s;
         edit_field_r <= field_of(state_nx_s);
      end
   end

   // Prescaler runs only while staying in RUN, so it restarts from 0 after a load.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         presc_r <= {PW{1'b0}};
         tick_r  <= 1'b0;
      end else if ((state_r != RUN) || (state_nx_s != RUN)) begin
         presc_r <= {PW{1'b0}};
         tick_r  <= 1'b0;
      end else if (presc_r == PRESC_MAX) begin
         presc_r <= {PW{1'b0}};
         tick_r  <= 1'b1;
      end else begin
         presc_r <= presc_r + PRESC_ONE;
         tick_r  <= 1'b0;
      end
   end

   // Blink half-period counter; restarts at 0 on entering set mode and in RUN.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_r <= {BW{1'b0}};
         blink_r     <= 1'b0;
      end else if ((state_nx_s == RUN) || (state_r == RUN)) begin
         blink_cnt_r <= {BW{1'b0}};
         blink_r     <= 1'b0;
      end else if (blink_cnt_r == BLINK_MAX) begin
         blink_cnt_r <= {BW{1'b0}};
         blink_r     <= ~blink_r;
      end else begin
         blink_cnt_r <= blink_cnt_r + BLINK_ONE;
         blink_r     <= blink_r;
      end
   end

`ifdef CLOCK_ALARM_EN
   // Alarm time registers and latched alarm flag.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         alm_h_r <= 6'd0;
         alm_m_r <= 6'd0;
         alarm_r <= 1'b0;
      end else begin
         alm_h_r <= alm_h_nx_s;
         alm_m_r <= alm_m_nx_s;
         alarm_r <= alarm_nx_s;
      end
   end

   assign alarm = alarm_r;
`endif

   assign tick         = tick_r;
   assign load         = load_r;
   assign load_hours   = sh_h_r;
   assign load_minutes = sh_m_r;
   assign load_seconds = sh_s_r;
   assign edit_field   = edit_field_r;
   assign blink        = blink_r;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with CLK_HZ=4, BLINK_DIV=2 (default build).
module tb_clock_set_controller;

   logic       clk;
   logic       reset;
   logic       mode_btn;
   logic       inc_btn;
   logic [5:0] cur_hours;
   logic [5:0] cur_minutes;
   logic [5:0] cur_seconds;
   logic       tick;
   logic       load;
   logic [5:0] load_hours;
   logic [5:0] load_minutes;
   logic [5:0] load_seconds;
   logic [1:0] edit_field;
   logic       blink;

   int checks_r   = 0;
   int failures_r = 0;

   clock_set_controller #(.CLK_HZ(4), .BLINK_DIV(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .mode_btn     (mode_btn),
      .inc_btn      (inc_btn),
      .cur_hours    (cur_hours),
      .cur_minutes  (cur_minutes),
      .cur_seconds  (cur_seconds),
      .tick         (tick),
      .load         (load),
      .load_hours   (load_hours),
      .load_minutes (load_minutes),
      .load_seconds (load_seconds),
      .edit_field   (edit_field),
      .blink        (blink)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks_r++;
      if (got !== exp) begin
         failures_r++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_tick"}, 32'(tick), 32'd0);
      check({tag, "_load"}, 32'(load), 32'd0);
      check({tag, "_lh"}, 32'(load_hours), 32'd0);
      check({tag, "_lm"}, 32'(load_minutes), 32'd0);
      check({tag, "_ls"}, 32'(load_seconds), 32'd0);
      check({tag, "_field"}, 32'(edit_field), 32'd0);
      check({tag, "_blink"}, 32'(blink), 32'd0);
   endtask

   task automatic press(input logic m, input logic i);
      mode_btn = m;
      inc_btn  = i;
      step();
      mode_btn = 1'b0;
      inc_btn  = 1'b0;
   endtask

   initial begin
      logic exp_blink [4];
      exp_blink[0] = 1'b0; exp_blink[1] = 1'b1; exp_blink[2] = 1'b1; exp_blink[3] = 1'b0;
      reset = 1'b1; mode_btn = 1'b0; inc_btn = 1'b0;
      cur_hours = 6'd0; cur_minutes = 6'd0; cur_seconds = 6'd0;
      repeat (2) step();
      check_all_zero("reset");
      reset = 1'b0;

      // Free-running ticks every 4th cycle after reset release.
      for (int i = 1; i <= 20; i++) begin
         step();
         check($sformatf("run_tick_c%0d", i), 32'(tick), (i % 4 == 0) ? 32'd1 : 32'd0);
         check($sformatf("run_load_c%0d", i), 32'(load), 32'd0);
      end

      // Capture 23:59:58, wrap hours, then commit.
      cur_hours = 6'd23; cur_minutes = 6'd59; cur_seconds = 6'd58;
      press(1'b1, 1'b0);
      check("seth_field", 32'(edit_field), 32'd1);
      check("seth_cap_h", 32'(load_hours), 32'd23);
      check("seth_tick", 32'(tick), 32'd0);
      press(1'b0, 1'b1);
      check("seth_wrap_h", 32'(load_hours), 32'd0);
      press(1'b1, 1'b0);
      check("setm_field", 32'(edit_field), 32'd2);
      press(1'b1, 1'b0);
      check("sets_field", 32'(edit_field), 32'd3);
      check("sets_noload", 32'(load), 32'd0);
      press(1'b1, 1'b0);
      check("commit_field", 32'(edit_field), 32'd0);
      check("commit_load", 32'(load), 32'd1);
      check("commit_tick", 32'(tick), 32'd0);
      check("commit_h", 32'(load_hours), 32'd0);
      check("commit_m", 32'(load_minutes), 32'd59);
      check("commit_s", 32'(load_seconds), 32'd58);

      // First tick exactly 4 cycles after the load strobe.
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("postload_tick_%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
         check($sformatf("postload_load_%0d", i), 32'(load), 32'd0);
      end
      check("run_blink", 32'(blink), 32'd0);

      // Blink cadence in SET_H.
      cur_hours = 6'd5; cur_minutes = 6'd7; cur_seconds = 6'd58;
      press(1'b1, 1'b0);
      check("blink_entry", 32'(blink), 32'd0);
      check("blink_cap_h", 32'(load_hours), 32'd5);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("blink_%0d", i), 32'(blink), 32'(exp_blink[i]));
         check($sformatf("blink_tick_%0d", i), 32'(tick), 32'd0);
      end

      // Seconds wrap without carry, then mode+inc in the same cycle.
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      check("sets2_field", 32'(edit_field), 32'd3);
      press(1'b0, 1'b1);
      check("sec_59", 32'(load_seconds), 32'd59);
      press(1'b0, 1'b1);
      check("sec_wrap", 32'(load_seconds), 32'd0);
      check("sec_nocarry_m", 32'(load_minutes), 32'd7);
      check("sec_nocarry_h", 32'(load_hours), 32'd5);
      press(1'b1, 1'b1);
      check("modeinc_field", 32'(edit_field), 32'd0);
      check("modeinc_load", 32'(load), 32'd1);
      check("modeinc_s", 32'(load_seconds), 32'd0);
      check("modeinc_blink", 32'(blink), 32'd0);
      step();
      check("modeinc_load_off", 32'(load), 32'd0);
      press(1'b0, 1'b1);
      check("runinc_field", 32'(edit_field), 32'd0);
      check("runinc_h", 32'(load_hours), 32'd5);
      check("runinc_load", 32'(load), 32'd0);

      // Reset mid-SET_M after three increments.
      press(1'b1, 1'b0);
      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      check("pre_reset_m", 32'(load_minutes), 32'd10);
      check("pre_reset_field", 32'(edit_field), 32'd2);
      #2 reset = 1'b1;
      #1;
      check_all_zero("async_reset");
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("inreset_load_%0d", i), 32'(load), 32'd0);
      end
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check($sformatf("rel_load_%0d", i), 32'(load), 32'd0);
         check($sformatf("rel_field_%0d", i), 32'(edit_field), 32'd0);
         check($sformatf("rel_tick_%0d", i), 32'(tick), (i == 4) ? 32'd1 : 32'd0);
      end
      check("rel_lm", 32'(load_minutes), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
      $finish;
   end

endmodule
